// File: rtl/mult_arbiter_if.sv
// Request/grant/result bundle shared by the two requesters of mult_arbiter.
// The slave modport is the arbiter side; master is the requester side.
interface mult_arbiter_if #(
  parameter int OPER_LENGTH = 3
);
  logic                       req0;
  logic                       req1;
  logic [OPER_LENGTH-1:0]     operX0;
  logic [OPER_LENGTH-1:0]     operY0;
  logic [OPER_LENGTH-1:0]     operX1;
  logic [OPER_LENGTH-1:0]     operY1;
  logic                       ack0;
  logic                       ack1;
  logic                       valid0;
  logic                       valid1;
  logic [2*OPER_LENGTH-1:0]   result;
  logic                       busy;

  modport slave (
    input  req0, req1, operX0, operY0, operX1, operY1,
    output ack0, ack1, valid0, valid1, result, busy
  );

  modport master (
    output req0, req1, operX0, operY0, operX1, operY1,
    input  ack0, ack1, valid0, valid1, result, busy
  );
endinterface

// File: rtl/mult_arbiter.sv
// Two-requester arbiter sharing one multicycle combinational array multiplier.
// Define MULT_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mult_arbiter #(
  parameter int OPER_LENGTH   = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  mult_arbiter_if.slave bus
);
  localparam int RES_W = 2 * OPER_LENGTH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic                   w_grant;
  logic                   w_winner;
  logic                   w_capture;
  logic                   w_finish;
  logic [OPER_LENGTH-1:0] r_operX;
  logic [OPER_LENGTH-1:0] r_operY;
  logic [3:0]             r_count;
  logic                   r_grantId;
  logic                   r_ack0;
  logic                   r_ack1;
  logic                   r_valid0;
  logic                   r_valid1;
  logic [RES_W-1:0]       r_result;
  logic [RES_W-1:0]       w_product;

`ifdef MULT_ARBITER_RR_EN
  logic r_prio;

  // r_prio names the requester that wins the next tie: the one not granted last.
  assign w_winner = (bus.req0 && bus.req1) ? r_prio : bus.req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_grant) begin
      r_prio <= ~w_winner;
    end
  end
`else
  assign w_winner = ~bus.req0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_grant     = 1'b1;
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (r_count == 4'd1) begin
          w_capture   = 1'b1;
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_finish    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Ack and Valid are registered, so each appears in the cycle after its deciding edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_valid0  <= 1'b0;
      r_valid1  <= 1'b0;
      r_grantId <= 1'b0;
      r_operX   <= '0;
      r_operY   <= '0;
      r_count   <= '0;
      r_result  <= '0;
    end else begin
      r_ack0   <= w_grant && !w_winner;
      r_ack1   <= w_grant && w_winner;
      r_valid0 <= w_finish && !r_grantId;
      r_valid1 <= w_finish && r_grantId;
      if (w_grant) begin
        r_grantId <= w_winner;
        r_operX   <= w_winner ? bus.operX1 : bus.operX0;
        r_operY   <= w_winner ? bus.operY1 : bus.operY0;
        r_count   <= 4'(SETTLE_CYCLES);
      end else if (r_state == WAIT) begin
        r_count <= r_count - 4'd1;
      end
      if (w_capture) begin
        r_result <= w_product;
      end
    end
  end

  ArrayMultiplier #(
    .OPER1_LENGTH (OPER_LENGTH),
    .OPER2_LENGTH (OPER_LENGTH)
  ) u_mult (
    .i_operA   (r_operX),
    .i_operB   (r_operY),
    .o_product (w_product)
  );

  assign bus.ack0   = r_ack0;
  assign bus.ack1   = r_ack1;
  assign bus.valid0 = r_valid0;
  assign bus.valid1 = r_valid1;
  assign bus.result = r_result;
  // Busy also covers the registered Valid cycle so it spans Ack through Valid.
  assign bus.busy   = (r_state != IDLE) || r_valid0 || r_valid1;
endmodule

module ArrayMultiplier #(
  parameter int OPER1_LENGTH = 3,
  parameter int OPER2_LENGTH = 3
) (
  input  logic [OPER1_LENGTH-1:0]              i_operA,
  input  logic [OPER2_LENGTH-1:0]              i_operB,
  output logic [OPER1_LENGTH+OPER2_LENGTH-1:0] o_product
);
  logic [OPER1_LENGTH:0] w_acc;
  logic [OPER1_LENGTH:0] w_rowSum;
  logic                  w_a;
  logic                  w_b;
  logic                  w_carry;

  // Each row ripple-adds one partial product to the upper bits of the previous row;
  // the low bit of every row retires one product bit.
  always_comb begin
    w_acc     = '0;
    w_rowSum  = '0;
    w_a       = 1'b0;
    w_b       = 1'b0;
    w_carry   = 1'b0;
    o_product = '0;
    for (int i = 0; i < OPER1_LENGTH; i++) begin
      w_acc[i] = i_operA[i] & i_operB[0];
    end
    o_product[0] = w_acc[0];
    for (int j = 1; j < OPER2_LENGTH; j++) begin
      w_carry = 1'b0;
      for (int i = 0; i < OPER1_LENGTH; i++) begin
        w_a         = w_acc[i+1];
        w_b         = i_operA[i] & i_operB[j];
        w_rowSum[i] = w_a ^ w_b ^ w_carry;
        w_carry     = (w_a & w_b) | (w_carry & (w_a ^ w_b));
      end
      w_rowSum[OPER1_LENGTH] = w_carry;
      w_acc                  = w_rowSum;
      o_product[j]           = w_acc[0];
    end
    o_product[OPER1_LENGTH+OPER2_LENGTH-1:OPER2_LENGTH] = w_acc[OPER1_LENGTH:1];
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed vector table, corner sequences,
// and randomized traffic against a transaction-level timing model.
module tb_mult_arbiter;
  localparam int OPER_LENGTH   = 3;
  localparam int SETTLE_CYCLES = 2;

  logic clk;
  logic rst;

  mult_arbiter_if #(.OPER_LENGTH(OPER_LENGTH)) bus ();

  mult_arbiter #(
    .OPER_LENGTH   (OPER_LENGTH),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic       req0;
    logic       req1;
    logic [2:0] x0;
    logic [2:0] y0;
    logic [2:0] x1;
    logic [2:0] y1;
    int         expId;
    logic [5:0] expResult;
  } vec_t;

  vec_t vecs [4];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic [2:0] x0, input logic [2:0] y0,
                               input logic [2:0] x1, input logic [2:0] y1);
    bus.req0   = r0;
    bus.req1   = r1;
    bus.operX0 = x0;
    bus.operY0 = y0;
    bus.operX1 = x1;
    bus.operY1 = y1;
  endtask

  // Waits for the next Ack (forValid=0) or Valid (forValid=1); id is -1 on timeout.
  task automatic waitFor(input bit forValid, output int cycles, output int id);
    bit found;
    found  = 1'b0;
    cycles = 0;
    id     = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (forValid ? (bus.valid0 || bus.valid1) : (bus.ack0 || bus.ack1)) begin
        found = 1'b1;
        id    = forValid ? (bus.valid1 ? 1 : 0) : (bus.ack1 ? 1 : 0);
      end
    end
    if (!found) checkOutput(forValid ? "validTimeout" : "ackTimeout", 32'd0, 32'd1);
  endtask

  // Transaction model: a grant at edge g gives Ack in cycle g, Result from g+S,
  // Valid in g+S+1, Busy over g..g+S+1, and the next grant no earlier than edge g+S+2.
  int         cyc = 0;
  int         gEdge;
  int         nextFree;
  int         gId;
  int         lastWinner;
  logic [2:0] gX;
  logic [2:0] gY;
  logic [5:0] expResult;
  logic       expAck0, expAck1, expValid0, expValid1, expBusy;

  task automatic modelReset();
    gEdge      = -1000;
    nextFree   = 0;
    gId        = 0;
    lastWinner = 1;
    gX         = '0;
    gY         = '0;
    expResult  = '0;
  endtask

  initial modelReset();

  always @(posedge rst) modelReset();

  always begin
    int winner;
    @(posedge clk);
    cyc++;
    expAck0   = 1'b0;
    expAck1   = 1'b0;
    expValid0 = 1'b0;
    expValid1 = 1'b0;
    if (rst) begin
      modelReset();
    end else begin
      if (cyc == gEdge + SETTLE_CYCLES) expResult = 6'(gX) * 6'(gY);
      if (cyc == gEdge + SETTLE_CYCLES + 1) begin
        if (gId == 0) expValid0 = 1'b1;
        else          expValid1 = 1'b1;
      end
      if (cyc >= nextFree && (bus.req0 || bus.req1)) begin
`ifdef MULT_ARBITER_RR_EN
        if (bus.req0 && bus.req1) winner = (lastWinner == 0) ? 1 : 0;
        else                      winner = bus.req0 ? 0 : 1;
`else
        winner = bus.req0 ? 0 : 1;
`endif
        lastWinner = winner;
        gId        = winner;
        gEdge      = cyc;
        nextFree   = cyc + SETTLE_CYCLES + 2;
        gX         = (winner == 0) ? bus.operX0 : bus.operX1;
        gY         = (winner == 0) ? bus.operY0 : bus.operY1;
        if (winner == 0) expAck0 = 1'b1;
        else             expAck1 = 1'b1;
      end
    end
    expBusy = (cyc >= gEdge) && (cyc <= gEdge + SETTLE_CYCLES + 1);
    #1;
    checkOutput("ctrl{ack0,ack1,valid0,valid1,busy}",
                {27'd0, bus.ack0, bus.ack1, bus.valid0, bus.valid1, bus.busy},
                {27'd0, expAck0, expAck1, expValid0, expValid1, expBusy});
    checkOutput("result", {26'd0, bus.result}, {26'd0, expResult});
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cycles;
    int  id;
    int  expGrants [3];
    bit  sawValid;

    vecs[0] = '{req0: 1'b1, req1: 1'b0, x0: 3'd5, y0: 3'd6, x1: 3'd0, y1: 3'd0, expId: 0, expResult: 6'd30};
    vecs[1] = '{req0: 1'b0, req1: 1'b1, x0: 3'd0, y0: 3'd0, x1: 3'd7, y1: 3'd7, expId: 1, expResult: 6'd49};
    vecs[2] = '{req0: 1'b1, req1: 1'b0, x0: 3'd0, y0: 3'd7, x1: 3'd3, y1: 3'd3, expId: 0, expResult: 6'd0};
    vecs[3] = '{req0: 1'b0, req1: 1'b1, x0: 3'd6, y0: 3'd6, x1: 3'd1, y1: 3'd1, expId: 1, expResult: 6'd1};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetCtrl", {27'd0, bus.ack0, bus.ack1, bus.valid0, bus.valid1, bus.busy}, 32'd0);
    checkOutput("resetResult", {26'd0, bus.result}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].req0, vecs[i].req1, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1);
      waitFor(1'b0, cycles, id);
      checkOutput($sformatf("vec%0d_ackDelay", i), cycles, 1);
      checkOutput($sformatf("vec%0d_ackId", i), id, vecs[i].expId);
      applyStimulus(1'b0, 1'b0, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1);
      waitFor(1'b1, cycles, id);
      checkOutput($sformatf("vec%0d_validLatency", i), cycles, SETTLE_CYCLES + 1);
      checkOutput($sformatf("vec%0d_validId", i), id, vecs[i].expId);
      checkOutput($sformatf("vec%0d_result", i), {26'd0, bus.result}, {26'd0, vecs[i].expResult});
    end

    // Tie held for three operations.
`ifdef MULT_ARBITER_RR_EN
    expGrants = '{0, 1, 0};
`else
    expGrants = '{0, 0, 0};
`endif
    applyStimulus(1'b1, 1'b1, 3'd2, 3'd3, 3'd4, 3'd5);
    waitFor(1'b0, cycles, id);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("tie%0d_grant", k), id, expGrants[k]);
      if (k == 2) applyStimulus(1'b0, 1'b0, 3'd2, 3'd3, 3'd4, 3'd5);
      waitFor(1'b1, cycles, id);
      checkOutput($sformatf("tie%0d_result", k), {26'd0, bus.result},
                  (expGrants[k] == 0) ? 32'd6 : 32'd20);
      if (k < 2) begin
        waitFor(1'b0, cycles, id);
        checkOutput($sformatf("tie%0d_spacing", k), cycles, 1);
      end
    end

    // Operand change while the operation is in flight.
    applyStimulus(1'b1, 1'b0, 3'd3, 3'd3, 3'd0, 3'd0);
    waitFor(1'b0, cycles, id);
    applyStimulus(1'b0, 1'b0, 3'd7, 3'd3, 3'd0, 3'd0);
    waitFor(1'b1, cycles, id);
    checkOutput("operChange_result", {26'd0, bus.result}, 32'd9);

    // Reset pulsed in the second WAIT cycle.
    applyStimulus(1'b1, 1'b0, 3'd6, 3'd6, 3'd0, 3'd0);
    waitFor(1'b0, cycles, id);
    applyStimulus(1'b0, 1'b0, 3'd6, 3'd6, 3'd0, 3'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midReset_ctrl", {27'd0, bus.ack0, bus.ack1, bus.valid0, bus.valid1, bus.busy}, 32'd0);
    checkOutput("midReset_result", {26'd0, bus.result}, 32'd0);
    #3 rst = 1'b0;
    sawValid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid0 || bus.valid1) sawValid = 1'b1;
    end
    checkOutput("midReset_noValid", {31'd0, sawValid}, 32'd0);
    applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 3'd2, 3'd2);
    waitFor(1'b0, cycles, id);
    checkOutput("postReset_ackId", id, 1);
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd2, 3'd2);
    waitFor(1'b1, cycles, id);
    checkOutput("postReset_result", {26'd0, bus.result}, 32'd4);

    // Req0 held continuously: Acks every S+2 cycles.
    applyStimulus(1'b1, 1'b0, 3'd3, 3'd4, 3'd0, 3'd0);
    waitFor(1'b0, cycles, id);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) applyStimulus(1'b0, 1'b0, 3'd3, 3'd4, 3'd0, 3'd0);
      waitFor(1'b1, cycles, id);
      checkOutput($sformatf("b2b%0d_result", k), {26'd0, bus.result}, 32'd12);
      if (k < 2) begin
        waitFor(1'b0, cycles, id);
        checkOutput($sformatf("b2b%0d_spacing", k), cycles + SETTLE_CYCLES + 1, SETTLE_CYCLES + 2);
        checkOutput($sformatf("b2b%0d_ackId", k), id, 0);
      end
    end

    // Randomized traffic; the per-cycle model comparison does the checking.
    repeat (4) @(posedge clk);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (bus.req0 && bus.ack0) begin
        if ($urandom_range(1, 0) == 1) bus.req0 = 1'b0;
        bus.operX0 = 3'($urandom_range(7, 0));
        bus.operY0 = 3'($urandom_range(7, 0));
      end else if (!bus.req0 && $urandom_range(9, 0) < 4) begin
        bus.req0   = 1'b1;
        bus.operX0 = 3'($urandom_range(7, 0));
        bus.operY0 = 3'($urandom_range(7, 0));
      end
      if (bus.req1 && bus.ack1) begin
        if ($urandom_range(1, 0) == 1) bus.req1 = 1'b0;
        bus.operX1 = 3'($urandom_range(7, 0));
        bus.operY1 = 3'($urandom_range(7, 0));
      end else if (!bus.req1 && $urandom_range(9, 0) < 4) begin
        bus.req1   = 1'b1;
        bus.operX1 = 3'($urandom_range(7, 0));
        bus.operY1 = 3'($urandom_range(7, 0));
      end
      if ($urandom_range(99, 0) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    repeat (SETTLE_CYCLES + 4) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
